// File: rtl/shared_pkg.sv
// Shared constants for the programmable FIFO and its bench.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shared_pkg;

    localparam int FIFO_WIDTH    = 16;
    localparam int FIFO_DEPTH    = 8;
    localparam int max_fifo_addr = $clog2(FIFO_DEPTH);
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;

    // Stimulus knobs for randomised benches (enable switches and
    // percentage of cycles with the request asserted).
    localparam int RD_ACTIVE     = 1;
    localparam int WR_ACTIVE     = 1;
    localparam int RD_EN_ON_DIST = 30;
    localparam int WR_EN_ON_DIST = 70;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller only asserts we for accepted writes.
module fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; stale words are never exposed
    // because the count gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds.
// Latency: read data 1 cycle after accepted read; with FIFO_FWFT_EN the head word is shown directly.
// Backpressure: writes to a full FIFO are rejected (overflow pulse) unless a read frees a slot the same cycle.
module fifo_prog
    import shared_pkg::*;
#(
    parameter int  FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int  FIFO_DEPTH = shared_pkg::FIFO_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [FIFO_WIDTH-1:0] head;
    logic                  wr_acc;
    logic                  rd_acc;

    // A read never happens from empty; a write into a full FIFO is only
    // allowed when a read vacates a slot on the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= af_level);
    assign almostempty = (count <= ae_level);

    fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && rst_n),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer, occupancy and pulse state; pointers wrap at FIFO_DEPTH-1
    // so non power-of-two depths work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full && !rd_acc;
            underflow <= rd_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // First-word fall-through: the head word is always visible, zero when empty.
    assign data_out = empty ? '0 : head;
`else
    // Registered read: capture the head word on each accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= head;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog (standard or FIFO_FWFT_EN build).
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_prog;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          wr_en;
    logic          rd_en;
    logic [CW-1:0] af_level;
    logic [CW-1:0] ae_level;
    logic [W-1:0]  data_out;
    logic          wr_ack;
    logic          overflow;
    logic          underflow;
    logic          full;
    logic          empty;
    logic          almostfull;
    logic          almostempty;
    logic [CW-1:0] count;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_prog #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .af_level    (af_level),
        .ae_level    (ae_level),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        data_in = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    // Read one word and compare it against the expected value in the
    // way each read mode presents it.
    task automatic pop_check(input string tag, input logic [W-1:0] exp);
`ifdef FIFO_FWFT_EN
        check(tag, 32'(data_out), 32'(exp));
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
        check(tag, 32'(data_out), 32'(exp));
`endif
    endtask

    initial begin
        int acks;
        rst_n    = 1'b0;
        data_in  = '0;
        wr_en    = 1'b1;
        rd_en    = 1'b1;
        af_level = CW'(6);
        ae_level = CW'(2);
        tick();
        tick();
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Reset state
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_wr_ack", 32'(wr_ack), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_ae", 32'(almostempty), 1);
        check("rst_af", 32'(almostfull), 0);

        // Fill 1..8, thresholds af=6 ae=2
        acks = 0;
        for (int i = 1; i <= 8; i++) begin
            push(W'(i));
            if (wr_ack) acks++;
            check("fill_count", 32'(count), 32'(i));
            check("fill_af", 32'(almostfull), (i >= 6) ? 1 : 0);
            check("fill_ae", 32'(almostempty), (i <= 2) ? 1 : 0);
        end
        check("fill_acks", 32'(acks), 8);
        check("fill_full", 32'(full), 1);

        // Ninth write is rejected
        push(16'h0099);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_no_ack", 32'(wr_ack), 0);
        check("ovf_count", 32'(count), 8);
        tick();
        check("ovf_clear", 32'(overflow), 0);

        // Full with simultaneous read and write
`ifdef FIFO_FWFT_EN
        check("fullrw_data", 32'(data_out), 32'h0001);
`endif
        data_in = 16'h0009;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
`ifndef FIFO_FWFT_EN
        check("fullrw_data", 32'(data_out), 32'h0001);
`endif
        check("fullrw_count", 32'(count), 8);
        check("fullrw_ovf", 32'(overflow), 0);
        check("fullrw_ack", 32'(wr_ack), 1);

        // Drain: 2..9 in order
        for (int i = 2; i <= 9; i++) begin
            pop_check("drain_data", W'(i));
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);
`ifdef FIFO_FWFT_EN
        check("drain_data_zero", 32'(data_out), 0);
`endif

        // Empty with simultaneous read and write
        data_in = 16'h00AA;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("emptyrw_udf", 32'(underflow), 1);
        check("emptyrw_count", 32'(count), 1);
        check("emptyrw_ack", 32'(wr_ack), 1);
`ifdef FIFO_FWFT_EN
        check("emptyrw_data", 32'(data_out), 32'h00AA);
`else
        check("emptyrw_hold", 32'(data_out), 32'h0009);
`endif
        pop_check("emptyrw_pop", 16'h00AA);
        check("emptyrw_udf_clr", 32'(underflow), 0);

        // Plain underflow
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf_pulse", 32'(underflow), 1);
        check("udf_count", 32'(count), 0);
        tick();
        check("udf_clear", 32'(underflow), 0);

        // 20 interleaved writes and reads, pointers wrap
        for (int k = 0; k < 20; k++) begin
            push(W'(16'h0100 + k));
            pop_check("wrap_data", W'(16'h0100 + k));
        end
        check("wrap_empty", 32'(empty), 1);

        // Mid-stream reset at count=5
        for (int i = 0; i < 5; i++) begin
            push(W'(16'h0200 + i));
        end
        check("pre_rst_count", 32'(count), 5);
        rst_n = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 16'h0BAD;
        tick();
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_data", 32'(data_out), 0);
        check("mid_rst_ack", 32'(wr_ack), 0);
        push(16'h0300);
        check("post_rst_count", 32'(count), 1);
        pop_check("post_rst_data", 16'h0300);
        check("post_rst_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
